servo_pwm_scheduler: RTL and testbench

// Two-channel hobby-servo PWM generator/scheduler, driven by the 8-bit servo_1/servo_2 position PIO exports.

---
 rtl/servo_pwm_scheduler.sv | 152 +++++++++++++++
 tb/tb_servo_pwm_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_scheduler.sv
// Two-channel hobby-servo PWM generator with frame-aligned position latching,
// per-frame slew limiting and a clean stop at the end of the current frame.
module servo_pwm_scheduler #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned US_PER_CODE = 4,
  parameter int unsigned SLEW_STEP   = 8,
  parameter int unsigned INIT_POS    = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] servo_1_pos,
  input  logic [7:0] servo_2_pos,
  output logic       pwm_1,
  output logic       pwm_2,
  output logic       frame_start,
  output logic [7:0] cur_1_pos,
  output logic [7:0] cur_2_pos,
  output logic       busy
);

  localparam int unsigned CycPerUs = CLK_HZ / 1000000;
  localparam int unsigned PsW      = (CycPerUs > 1) ? $clog2(CycPerUs) : 1;
  localparam int unsigned FrW      = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(CycPerUs - 1);
  localparam logic [FrW-1:0] FrLast = FrW'(PERIOD_US - 1);

  typedef enum logic [0:0] {StDisabled, StFrame} state_e;

  state_e         state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [FrW-1:0] frame_us_q, frame_us_d;
  logic [FrW-1:0] width_1_q, width_1_d, width_2_q, width_2_d;
  logic [7:0]     cur_1_q, cur_1_d, cur_2_q, cur_2_d;
  logic           pwm_1_q, pwm_1_d, pwm_2_q, pwm_2_d;
  logic           fs_q, fs_d;
  logic           tick, wrap, boundary;

  // Move cur toward tgt by at most SLEW_STEP codes (0 disables the limit).
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] d;
    logic [8:0]        mag;
    logic [7:0]        res;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[8] ? $unsigned(-d) : $unsigned(d);
    if (SLEW_STEP == 0 || 32'(mag) <= SLEW_STEP) begin
      res = tgt;
    end else if (d[8]) begin
      res = cur - 8'(SLEW_STEP);
    end else begin
      res = cur + 8'(SLEW_STEP);
    end
    return res;
  endfunction

  // Clamp keeps at least one low microsecond in every frame.
  function automatic logic [FrW-1:0] width_of(input logic [7:0] pos);
    logic [31:0] w;
    w = MIN_US + 32'(pos) * US_PER_CODE;
    if (w > PERIOD_US - 1) begin
      w = PERIOD_US - 1;
    end
    return FrW'(w);
  endfunction

  assign tick = (presc_q == PsLast);
  assign wrap = tick && (frame_us_q == FrLast);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    frame_us_d = frame_us_q;
    cur_1_d    = cur_1_q;
    cur_2_d    = cur_2_q;
    width_1_d  = width_1_q;
    width_2_d  = width_2_q;
    boundary   = 1'b0;

    unique case (state_q)
      StDisabled: begin
        presc_d    = '0;
        frame_us_d = '0;
        if (enable) begin
          state_d  = StFrame;
          boundary = 1'b1;
        end
      end
      StFrame: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          frame_us_d = wrap ? '0 : frame_us_q + 1'b1;
        end
        // enable is only looked at here, so a running frame always completes.
        if (wrap) begin
          if (enable) begin
            boundary = 1'b1;
          end else begin
            state_d = StDisabled;
          end
        end
      end
      default: state_d = StDisabled;
    endcase

    if (boundary) begin
      cur_1_d   = slew(cur_1_q, servo_1_pos);
      cur_2_d   = slew(cur_2_q, servo_2_pos);
      width_1_d = width_of(cur_1_d);
      width_2_d = width_of(cur_2_d);
    end

    fs_d    = boundary;
    pwm_1_d = (state_d == StFrame) && (frame_us_d < width_1_d);
    pwm_2_d = (state_d == StFrame) && (frame_us_d < width_2_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StDisabled;
      presc_q    <= '0;
      frame_us_q <= '0;
      width_1_q  <= '0;
      width_2_q  <= '0;
      cur_1_q    <= 8'(INIT_POS);
      cur_2_q    <= 8'(INIT_POS);
      pwm_1_q    <= 1'b0;
      pwm_2_q    <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      frame_us_q <= frame_us_d;
      width_1_q  <= width_1_d;
      width_2_q  <= width_2_d;
      cur_1_q    <= cur_1_d;
      cur_2_q    <= cur_2_d;
      pwm_1_q    <= pwm_1_d;
      pwm_2_q    <= pwm_2_d;
      fs_q       <= fs_d;
    end
  end

  assign pwm_1       = pwm_1_q;
  assign pwm_2       = pwm_2_q;
  assign frame_start = fs_q;
  assign cur_1_pos   = cur_1_q;
  assign cur_2_pos   = cur_2_q;
  assign busy        = (cur_1_q != servo_1_pos) || (cur_2_q != servo_2_pos);

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Bench for servo_pwm_scheduler: three instances (no slew, slew 16, short period)
// exercised in parallel with frame-level pulse measurements.
module tb_servo_pwm_scheduler;

  localparam int unsigned ClkHz     = 4000000;
  localparam int unsigned MinUs     = 1000;
  localparam int unsigned UsPerCode = 4;
  localparam int          CycPerUs  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn   [3];
  logic       en     [3];
  logic [7:0] p1     [3];
  logic [7:0] p2     [3];
  logic       pwm1_w [3];
  logic       pwm2_w [3];
  logic       fs_w   [3];
  logic       busy_w [3];
  logic [7:0] cur1_w [3];
  logic [7:0] cur2_w [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    int         hi1;
    int         hi2;
  } vec_t;
  vec_t tbl [4];

  typedef struct {
    int cur1;
    int busy;
    int hi1;
  } sb_t;
  sb_t sbq [$];

  servo_pwm_scheduler #(
    .CLK_HZ(ClkHz), .PERIOD_US(3000), .MIN_US(MinUs), .US_PER_CODE(UsPerCode),
    .SLEW_STEP(0), .INIT_POS(128)
  ) u0 (
    .clk(clk), .reset_n(rstn[0]), .enable(en[0]), .servo_1_pos(p1[0]), .servo_2_pos(p2[0]),
    .pwm_1(pwm1_w[0]), .pwm_2(pwm2_w[0]), .frame_start(fs_w[0]), .cur_1_pos(cur1_w[0]),
    .cur_2_pos(cur2_w[0]), .busy(busy_w[0])
  );

  servo_pwm_scheduler #(
    .CLK_HZ(ClkHz), .PERIOD_US(3000), .MIN_US(MinUs), .US_PER_CODE(UsPerCode),
    .SLEW_STEP(16), .INIT_POS(128)
  ) u1 (
    .clk(clk), .reset_n(rstn[1]), .enable(en[1]), .servo_1_pos(p1[1]), .servo_2_pos(p2[1]),
    .pwm_1(pwm1_w[1]), .pwm_2(pwm2_w[1]), .frame_start(fs_w[1]), .cur_1_pos(cur1_w[1]),
    .cur_2_pos(cur2_w[1]), .busy(busy_w[1])
  );

  servo_pwm_scheduler #(
    .CLK_HZ(ClkHz), .PERIOD_US(2000), .MIN_US(MinUs), .US_PER_CODE(UsPerCode),
    .SLEW_STEP(0), .INIT_POS(128)
  ) u2 (
    .clk(clk), .reset_n(rstn[2]), .enable(en[2]), .servo_1_pos(p1[2]), .servo_2_pos(p2[2]),
    .pwm_1(pwm1_w[2]), .pwm_2(pwm2_w[2]), .frame_start(fs_w[2]), .cur_1_pos(cur1_w[2]),
    .cur_2_pos(cur2_w[2]), .busy(busy_w[2])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int hi_cycles(input int pos, input int period);
    int w;
    w = MinUs + pos * UsPerCode;
    if (w > period - 1) w = period - 1;
    return w * CycPerUs;
  endfunction

  // Starts on a frame_start cycle; counts high cycles until the next
  // frame_start or the limit, applying new inputs at cycle index change_at.
  task automatic measure(input int k, input int change_at, input logic n_en,
                         input logic [7:0] n_p1, input logic [7:0] n_p2, input int limit,
                         output int hi1, output int hi2, output int len, output int got_fs);
    hi1 = 0; hi2 = 0; len = 0; got_fs = 0;
    while (len < limit) begin
      if (len == change_at) begin
        en[k] = n_en;
        p1[k] = n_p1;
        p2[k] = n_p2;
      end
      hi1 += int'(pwm1_w[k]);
      hi2 += int'(pwm2_w[k]);
      len++;
      @(negedge clk);
      if (fs_w[k]) begin
        got_fs = 1;
        break;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0;
      en[k]   = 1'b0;
      p1[k]   = 8'd128;
      p2[k]   = 8'd128;
    end
    tbl[0] = '{8'd255, 8'd0,   7996, 4000};
    tbl[1] = '{8'd250, 8'd249, 7996, 7984};
    tbl[2] = '{8'd200, 8'd50,  7200, 4800};
    tbl[3] = '{8'd0,   8'd255, 4000, 7996};

    fork
      begin : br_basic
        int h1, h2, len, g, act;
        repeat (3) @(negedge clk);
        check("u0 reset pwm_1", pwm1_w[0], 0);
        check("u0 reset pwm_2", pwm2_w[0], 0);
        check("u0 reset frame_start", fs_w[0], 0);
        check("u0 reset cur_1", cur1_w[0], 128);
        check("u0 reset cur_2", cur2_w[0], 128);
        check("u0 reset busy", busy_w[0], 0);
        p1[0] = 8'd100;
        #1 check("u0 busy comb", busy_w[0], 1);
        p1[0] = 8'd128;
        rstn[0] = 1'b1;
        act = 0;
        repeat (10) begin
          @(negedge clk);
          act += int'(pwm1_w[0] | fs_w[0]);
        end
        check("u0 idle while disabled", act, 0);
        en[0] = 1'b1;
        @(negedge clk);
        check("u0 enable frame_start", fs_w[0], 1);
        check("u0 basic busy", busy_w[0], 0);
        // servo_2 drops to 0 at frame_us=500; this frame must be unaffected.
        measure(0, 2000, 1'b1, 8'd128, 8'd0, 12100, h1, h2, len, g);
        check("u0 f1 hi1", h1, 6048);
        check("u0 f1 hi2 midchange", h2, 6048);
        check("u0 f1 period", len, 12000);
        check("u0 f1 next fs", g, 1);
        check("u0 f2 cur_2", cur2_w[0], 0);
        measure(0, -1, 1'b1, 8'd128, 8'd0, 12100, h1, h2, len, g);
        check("u0 f2 hi1", h1, 6048);
        check("u0 f2 hi2", h2, hi_cycles(0, 3000));
        check("u0 f2 period", len, 12000);
        // Disable at frame_us=200: pulse completes, no following frame.
        measure(0, 800, 1'b0, 8'd128, 8'd0, 12100, h1, h2, len, g);
        check("u0 disable hi1", h1, 6048);
        check("u0 disable hi2", h2, 4000);
        check("u0 disable no fs", g, 0);
        check("u0 disable cur_1", cur1_w[0], 128);
        en[0] = 1'b1;
        @(negedge clk);
        check("u0 reenable frame_start", fs_w[0], 1);
        repeat (1200) @(negedge clk);
        check("u0 pre-reset pwm_1", pwm1_w[0], 1);
        check("u0 pre-reset pwm_2", pwm2_w[0], 1);
        rstn[0] = 1'b0;
        en[0]   = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        check("u0 midreset pwm_1", pwm1_w[0], 0);
        check("u0 midreset pwm_2", pwm2_w[0], 0);
        check("u0 midreset frame_start", fs_w[0], 0);
        check("u0 midreset cur_1", cur1_w[0], 128);
        check("u0 midreset cur_2", cur2_w[0], 128);
        check("u0 midreset busy", busy_w[0], 1);
        act = 0;
        repeat (10) begin
          @(negedge clk);
          act += int'(pwm1_w[0] | pwm2_w[0] | fs_w[0]);
        end
        check("u0 post-reset idle", act, 0);
        en[0] = 1'b1;
        @(negedge clk);
        check("u0 post-reset fs", fs_w[0], 1);
        check("u0 post-reset cur_2", cur2_w[0], 0);
      end

      begin : br_slew
        int h1, h2, len, g, c;
        sb_t e;
        repeat (3) @(negedge clk);
        check("u1 reset cur_1", cur1_w[1], 128);
        rstn[1] = 1'b1;
        @(negedge clk);
        c = 128;
        while (c != 200) begin
          c = (200 - c <= 16) ? 200 : c + 16;
          sbq.push_back('{c, int'(c != 200), hi_cycles(c, 3000)});
        end
        p1[1] = 8'd200;
        en[1] = 1'b1;
        @(negedge clk);
        check("u1 enable frame_start", fs_w[1], 1);
        while (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("u1 slew cur_1", cur1_w[1], e.cur1);
          check("u1 slew cur_2", cur2_w[1], 128);
          check("u1 slew busy", busy_w[1], e.busy);
          measure(1, -1, 1'b1, 8'd200, 8'd128, 12100, h1, h2, len, g);
          check("u1 slew hi1", h1, e.hi1);
          check("u1 slew next fs", g, 1);
        end
      end

      begin : br_clamp
        int h1, h2, len, g, nxt;
        repeat (3) @(negedge clk);
        rstn[2] = 1'b1;
        p1[2]   = tbl[0].p1;
        p2[2]   = tbl[0].p2;
        en[2]   = 1'b1;
        @(negedge clk);
        check("u2 enable frame_start", fs_w[2], 1);
        for (int i = 0; i < 4; i++) begin
          nxt = (i < 3) ? i + 1 : i;
          check("u2 vec cur_1", cur1_w[2], int'(tbl[i].p1));
          check("u2 vec cur_2", cur2_w[2], int'(tbl[i].p2));
          // Next vector arrives mid-frame and must wait for the boundary.
          measure(2, 3000, 1'b1, tbl[nxt].p1, tbl[nxt].p2, 8100, h1, h2, len, g);
          check("u2 vec hi1", h1, tbl[i].hi1);
          check("u2 vec hi2", h2, tbl[i].hi2);
          check("u2 vec period", len, 8000);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
